esp_uart_bus: RTL and testbench
===============================

Name: esp_uart_bus

Overview:
CPU-bus responder that exposes the aqp_esp_uart FIFOs as memory-mapped registers to the aq32 CPU. It sits on the CPU bus interconnect beside sram_ctrl, selected by an address decode in aq32_top. It drives the UART's txfifo_wr/rxfifo_rd strobes and raises an interrupt request on RX data or TX space.

Parameters:
- IRQ_TX_LEVEL, 1, when 1 the TX interrupt source is "TX FIFO not full"; when 0 the TX source is disabled.

Ports:
- clk  input  1  system clock (28.63636 MHz).
- reset  input  1  synchronous, active-high reset.
- bus_addr  input  2  word address within the block (cpu_addr[3:2]).
- bus_wrdata  input  32  write data.
- bus_bytesel  input  4  byte enables.
- bus_wren  input  1  1 = write, 0 = read.
- bus_strobe  input  1  access request; held until bus_wait=0.
- bus_wait  output  1  stall.
- bus_rddata  output  32  read data; valid when strobe=1 and wait=0.
- txfifo_data  output  9  byte plus bit 8 to UART.
- txfifo_wr  output  1  one-cycle push pulse.
- txfifo_full  input  1  UART TX FIFO full.
- rxfifo_data  input  9  show-ahead RX head; valid when !rxfifo_empty.
- rxfifo_rd  output  1  one-cycle pop pulse.
- rxfifo_empty  input  1  UART RX FIFO empty.
- rxfifo_overflow  input  1  one-cycle overflow pulse.
- rx_framing_error  input  1  one-cycle framing-error pulse.
- irq  output  1  level interrupt request.

Behaviour:
- Register map by bus_addr:
  - 0 DATA: read returns {bit31 = rx_empty, 22'b0, rxfifo_data[8:0]} and pops the head if not empty. Write pushes wrdata[8:0] when bytesel[0]=1.
  - 1 STATUS, read: bit0 rx_empty, bit1 tx_full, bit2 rx_overflow (sticky), bit3 framing_err (sticky), bit4 tx_drop (sticky). Write with bytesel[0]=1 clears each sticky bit whose wrdata bit is 1.
  - 2 CTRL, R/W: bit0 rx_irq_en, bit1 tx_irq_en. Write requires bytesel[0]=1.
  - 3: reads 0; writes ignored.
- FSM states and transitions:
  - IDLE: strobe=1 moves to ACCESS.
  - ACCESS: performs the action, captures rddata into a register, then moves to DONE (or stays in ACCESS, see tx full below).
  - DONE: moves to IDLE unconditionally.
- bus_wait = bus_strobe && state!=DONE. Minimum access is 2 wait cycles, completing in the 3rd cycle. A strobe still high after DONE is a new access.
- Address, wren, wrdata and bytesel are sampled in the IDLE→ACCESS cycle. bus_rddata is 0 whenever state!=DONE.
- rxfifo_rd and txfifo_wr pulse exactly once, in the ACCESS cycle that leaves for DONE. txfifo_data is registered.
- Read of DATA with rx_empty=1: returns bit31=1, no pop.
- Write of DATA with tx_full=1: the write is dropped, tx_drop is set, and the FSM proceeds to DONE (non-blocking default).
- Sticky bits are set by the input pulses.
  - A set pulse in the same cycle as a clear write wins: the bit stays 1.
- irq = (rx_irq_en && !rx_empty) || (tx_irq_en && IRQ_TX_LEVEL && !tx_full). It is combinational from registered/UART state.
- Reset, including mid-access: state=IDLE, bus_wait=0, bus_rddata=0, txfifo_wr=0, rxfifo_rd=0, txfifo_data=0, CTRL=0, stickies=0, irq=0. No push or pop occurs in the reset cycle.

Optional Feature:
- Macro ESP_UART_BUS_BLOCKING_EN.
- Defined: a DATA write while tx_full=1 holds the FSM in ACCESS (wait=1) until tx_full=0, then pushes and moves to DONE. tx_drop still exists but is never set by the bus.
- Undefined: the non-blocking drop behaviour above.

Decomposition:
- Shared package aq32_pkg: register index constants (REG_DATA=0, REG_STATUS=1, REG_CTRL=2), STATUS and CTRL bit-position constants, FSM state encoding.
- No sub-module; a single flat module is natural.

Test Plan:
- Reset, then read STATUS with both FIFOs empty → wait=1 for 2 cycles, rddata=0x00000001, irq=0.
- rxfifo_data=0x141, rxfifo_empty=0, read DATA → rddata=0x00000141; exactly one rxfifo_rd pulse. With the FIFO empty, a second read returns 0x80000000 and no pop.
- Write DATA 0x0000_0155 with bytesel=4'b0001, tx not full → one txfifo_wr pulse, txfifo_data=0x155. With bytesel=4'b0010 → no push.
- tx_full=1, write DATA 0x5A:
  - non-blocking: completes in 3 cycles, STATUS=0x13 with rx empty.
  - with ESP_UART_BUS_BLOCKING_EN: wait stays high until tx_full drops for 5 cycles, then exactly one push of 0x05A.
- Pulse rxfifo_overflow in the same cycle as a STATUS write of 0x4 → bit2 remains 1. A later write of 0x4 clears it.
- CTRL=0x1 with rx_empty 1→0 → irq rises the same cycle. Assert reset during ACCESS of a DATA read → no rxfifo_rd, wait=0 next cycle, CTRL reads 0.

Source files
------------

// File: rtl/aq32_pkg.sv
// Shared definitions for the aq32 CPU-bus UART responder.
// Holds the register index map, STATUS/CTRL bit positions and the
// bus-access FSM state encoding.
package aq32_pkg;

  // Register index (bus_addr = cpu_addr[3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // STATUS bit positions
  localparam int STAT_RX_EMPTY  = 0;
  localparam int STAT_TX_FULL   = 1;
  localparam int STAT_RX_OVF    = 2;
  localparam int STAT_FRAME_ERR = 3;
  localparam int STAT_TX_DROP   = 4;

  // CTRL bit positions
  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_TX_IRQ_EN = 1;

  // DATA read: bit position of the rx_empty flag
  localparam int DATA_RX_EMPTY  = 31;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } bus_state_e;

endpackage

// File: rtl/esp_uart_bus.sv
// Purpose : memory-mapped DATA/STATUS/CTRL registers over the UART FIFOs.
// Latency : 2 wait cycles minimum, access completes in the 3rd cycle.
// Backpr. : full TX FIFO drops the write; with ESP_UART_BUS_BLOCKING_EN it stalls.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   bus_addr/wrdata/bytesel/wren/strobe -> bus request (held until !bus_wait)
//   bus_wait, bus_rddata        stall and read data (non-zero only in DONE)
//   txfifo_data/wr, txfifo_full TX FIFO push side
//   rxfifo_data/rd/empty        RX FIFO show-ahead pop side
//   rxfifo_overflow, rx_framing_error  error pulses captured as sticky bits
//   irq                         level interrupt (RX data / TX space)
// Build option: ESP_UART_BUS_BLOCKING_EN selects stall-on-full for DATA writes.
module esp_uart_bus
  import aq32_pkg::*;
#(
  parameter logic IRQ_TX_LEVEL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wrdata,
  input  logic [3:0]  bus_bytesel,
  input  logic        bus_wren,
  input  logic        bus_strobe,
  output logic        bus_wait,
  output logic [31:0] bus_rddata,
  output logic [8:0]  txfifo_data,
  output logic        txfifo_wr,
  input  logic        txfifo_full,
  input  logic [8:0]  rxfifo_data,
  output logic        rxfifo_rd,
  input  logic        rxfifo_empty,
  input  logic        rxfifo_overflow,
  input  logic        rx_framing_error,
  output logic        irq
);

  bus_state_e  state_q;
  logic [1:0]  addr_q;
  logic        wren_q;
  logic        bsel0_q;
  logic [4:0]  wdata_q;
  logic [8:0]  txfifo_data_q;
  logic [31:0] rddata_q;
  logic [1:0]  ctrl_q;
  logic        rx_ovf_q, frame_err_q, tx_drop_q;
  logic        rx_ovf_d, frame_err_d, tx_drop_d;

  logic        is_data_wr, is_data_rd, is_status_wr, tx_blocked, acc_leave;
  logic [31:0] rd_val;
  logic [2:0]  clr;

  // Upper write-data bits and upper byte enables carry no register state.
  logic unused_bits;
  assign unused_bits = ^{bus_wrdata[31:9], bus_bytesel[3:1]};

  assign is_data_wr   = wren_q && (addr_q == REG_DATA) && bsel0_q;
  assign is_data_rd   = !wren_q && (addr_q == REG_DATA);
  assign is_status_wr = wren_q && (addr_q == REG_STATUS) && bsel0_q;

`ifdef ESP_UART_BUS_BLOCKING_EN
  assign tx_blocked = is_data_wr && txfifo_full;
`else
  assign tx_blocked = 1'b0;
`endif

  // The single ACCESS cycle that commits the action and heads to DONE.
  assign acc_leave = (state_q == S_ACCESS) && !tx_blocked;

  // Strobes are gated by reset so an interrupted access never pushes/pops.
  assign txfifo_wr = !reset && acc_leave && is_data_wr && !txfifo_full;
  assign rxfifo_rd = !reset && acc_leave && is_data_rd && !rxfifo_empty;

  assign bus_wait    = !reset && bus_strobe && (state_q != S_DONE);
  assign bus_rddata  = rddata_q;
  assign txfifo_data = txfifo_data_q;

  assign irq = !reset &&
               ((ctrl_q[CTRL_RX_IRQ_EN] && !rxfifo_empty) ||
                (ctrl_q[CTRL_TX_IRQ_EN] && IRQ_TX_LEVEL && !txfifo_full));

  // Read value of the addressed register; the RX data field is masked when
  // the FIFO is empty since the show-ahead head is not valid then.
  always_comb begin
    rd_val = '0;
    case (addr_q)
      REG_DATA: begin
        rd_val[DATA_RX_EMPTY] = rxfifo_empty;
        if (!rxfifo_empty) rd_val[8:0] = rxfifo_data;
      end
      REG_STATUS: begin
        rd_val[STAT_RX_EMPTY]  = rxfifo_empty;
        rd_val[STAT_TX_FULL]   = txfifo_full;
        rd_val[STAT_RX_OVF]    = rx_ovf_q;
        rd_val[STAT_FRAME_ERR] = frame_err_q;
        rd_val[STAT_TX_DROP]   = tx_drop_q;
      end
      REG_CTRL: rd_val[1:0] = ctrl_q;
      default: rd_val = '0;
    endcase
  end

  // Sticky bits: a set pulse in the clearing cycle takes precedence.
  always_comb begin
    clr = '0;
    if (acc_leave && is_status_wr)
      clr = {wdata_q[STAT_TX_DROP], wdata_q[STAT_FRAME_ERR], wdata_q[STAT_RX_OVF]};
    rx_ovf_d    = (rx_ovf_q    && !clr[0]) || rxfifo_overflow;
    frame_err_d = (frame_err_q && !clr[1]) || rx_framing_error;
    tx_drop_d   = (tx_drop_q   && !clr[2]) || (acc_leave && is_data_wr && txfifo_full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wren_q        <= 1'b0;
      bsel0_q       <= 1'b0;
      wdata_q       <= '0;
      txfifo_data_q <= '0;
      rddata_q      <= '0;
      ctrl_q        <= '0;
      rx_ovf_q      <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_drop_q     <= 1'b0;
    end else begin
      rx_ovf_q    <= rx_ovf_d;
      frame_err_q <= frame_err_d;
      tx_drop_q   <= tx_drop_d;
      case (state_q)
        S_IDLE: begin
          rddata_q <= '0;
          if (bus_strobe) begin
            state_q <= S_ACCESS;
            addr_q  <= bus_addr;
            wren_q  <= bus_wren;
            bsel0_q <= bus_bytesel[0];
            wdata_q <= bus_wrdata[4:0];
            if (bus_wren && (bus_addr == REG_DATA) && bus_bytesel[0])
              txfifo_data_q <= bus_wrdata[8:0];
          end
        end
        S_ACCESS: begin
          if (!tx_blocked) begin
            state_q  <= S_DONE;
            rddata_q <= wren_q ? 32'd0 : rd_val;
            if (wren_q && (addr_q == REG_CTRL) && bsel0_q)
              ctrl_q <= wdata_q[1:0];
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          rddata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esp_uart_bus.sv
// Directed self-checking bench for esp_uart_bus.
module tb_esp_uart_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wrdata;
  logic [3:0]  bus_bytesel;
  logic        bus_wren;
  logic        bus_strobe;
  logic        bus_wait;
  logic [31:0] bus_rddata;
  logic [8:0]  txfifo_data;
  logic        txfifo_wr;
  logic        txfifo_full;
  logic [8:0]  rxfifo_data;
  logic        rxfifo_rd;
  logic        rxfifo_empty;
  logic        rxfifo_overflow;
  logic        rx_framing_error;
  logic        irq;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] rdata;
  int          waits, rd_n, wr_n;
  logic [8:0]  txd;

  esp_uart_bus dut (
    .clk(clk), .reset(reset),
    .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_bytesel(bus_bytesel),
    .bus_wren(bus_wren), .bus_strobe(bus_strobe), .bus_wait(bus_wait),
    .bus_rddata(bus_rddata),
    .txfifo_data(txfifo_data), .txfifo_wr(txfifo_wr), .txfifo_full(txfifo_full),
    .rxfifo_data(rxfifo_data), .rxfifo_rd(rxfifo_rd), .rxfifo_empty(rxfifo_empty),
    .rxfifo_overflow(rxfifo_overflow), .rx_framing_error(rx_framing_error),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One bus access. Inputs change at negedge, outputs sampled 1ns later.
  // k counts cycles since strobe rose (0 = IDLE cycle, 1 = first ACCESS cycle).
  task automatic do_access(input logic [1:0] addr, input logic wren,
                           input logic [31:0] wdata, input logic [3:0] bsel,
                           input int ovf_at, input int rel_at,
                           output logic [31:0] rd, output int nw, output int nrd,
                           output int nwr, output logic [8:0] td);
    int k;
    k = 0; rd = '0; nw = 0; nrd = 0; nwr = 0; td = '0;
    @(negedge clk);
    bus_addr = addr; bus_wren = wren; bus_wrdata = wdata; bus_bytesel = bsel;
    bus_strobe = 1'b1;
    forever begin
      rxfifo_overflow = (k == ovf_at);
      if (k == rel_at) txfifo_full = 1'b0;
      #1;
      if (rxfifo_rd) nrd++;
      if (txfifo_wr) begin nwr++; td = txfifo_data; end
      if (!bus_wait) begin rd = bus_rddata; break; end
      nw++;
      if (nw > 50) begin
        n_cmp++; n_fail++;
        $display("FAIL access_timeout: wait still %b after %0d cycles, need 0", bus_wait, nw);
        break;
      end
      @(negedge clk);
      k++;
    end
    bus_strobe = 1'b0; bus_wren = 1'b0; rxfifo_overflow = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (bus_wait !== 1'b0) begin n_fail++; $display("FAIL rst_wait: got %b want 0", bus_wait); end
    n_cmp++; if (bus_rddata !== 32'h0) begin n_fail++; $display("FAIL rst_rddata: got %h want 0", bus_rddata); end
    n_cmp++; if ({txfifo_wr, rxfifo_rd} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes: got %b want 00", {txfifo_wr, rxfifo_rd}); end
    n_cmp++; if (txfifo_data !== 9'h0) begin n_fail++; $display("FAIL rst_txdata: got %h want 0", txfifo_data); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq); end
  endtask

  task automatic test_status;
    do_access(2'd1, 1'b0, 32'h0, 4'hF, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (waits !== 2) begin n_fail++; $display("FAIL status_waits: got %0d want 2", waits); end
    n_cmp++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL status_rd: got %h want 00000001", rdata); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL status_irq: got %b want 0", irq); end
    #1;
    n_cmp++; if (bus_wait !== 1'b0) begin n_fail++; $display("FAIL done_wait: got %b want 0", bus_wait); end
    do_access(2'd3, 1'b0, 32'h0, 4'hF, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reg3_rd: got %h want 0", rdata); end
  endtask

  task automatic test_data_read;
    rxfifo_data = 9'h141; rxfifo_empty = 1'b0;
    do_access(2'd0, 1'b0, 32'h0, 4'hF, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (rdata !== 32'h0000_0141) begin n_fail++; $display("FAIL data_rd: got %h want 00000141", rdata); end
    n_cmp++; if (rd_n !== 1) begin n_fail++; $display("FAIL data_pop: got %0d pops want 1", rd_n); end
    rxfifo_empty = 1'b1;
    do_access(2'd0, 1'b0, 32'h0, 4'hF, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (rdata !== 32'h8000_0000) begin n_fail++; $display("FAIL empty_rd: got %h want 80000000", rdata); end
    n_cmp++; if (rd_n !== 0) begin n_fail++; $display("FAIL empty_pop: got %0d pops want 0", rd_n); end
  endtask

  task automatic test_data_write;
    do_access(2'd0, 1'b1, 32'h0000_0155, 4'b0001, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (wr_n !== 1) begin n_fail++; $display("FAIL wr_push: got %0d pushes want 1", wr_n); end
    n_cmp++; if (txd !== 9'h155) begin n_fail++; $display("FAIL wr_txdata: got %h want 155", txd); end
    do_access(2'd0, 1'b1, 32'h0000_01AA, 4'b0010, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (wr_n !== 0) begin n_fail++; $display("FAIL wr_nobsel: got %0d pushes want 0", wr_n); end
    n_cmp++; if (waits !== 2) begin n_fail++; $display("FAIL wr_waits: got %0d want 2", waits); end
  endtask

  task automatic test_tx_full;
    txfifo_full = 1'b1;
`ifdef ESP_UART_BUS_BLOCKING_EN
    do_access(2'd0, 1'b1, 32'h0000_005A, 4'b0001, -1, 5, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (waits !== 6) begin n_fail++; $display("FAIL blk_waits: got %0d want 6", waits); end
    n_cmp++; if (wr_n !== 1) begin n_fail++; $display("FAIL blk_push: got %0d pushes want 1", wr_n); end
    n_cmp++; if (txd !== 9'h05A) begin n_fail++; $display("FAIL blk_txdata: got %h want 05a", txd); end
    do_access(2'd1, 1'b0, 32'h0, 4'hF, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (rdata !== 32'h01) begin n_fail++; $display("FAIL blk_status: got %h want 00000001", rdata); end
`else
    do_access(2'd0, 1'b1, 32'h0000_005A, 4'b0001, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (waits !== 2) begin n_fail++; $display("FAIL drop_waits: got %0d want 2", waits); end
    n_cmp++; if (wr_n !== 0) begin n_fail++; $display("FAIL drop_push: got %0d pushes want 0", wr_n); end
    do_access(2'd1, 1'b0, 32'h0, 4'hF, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (rdata !== 32'h13) begin n_fail++; $display("FAIL drop_status: got %h want 00000013", rdata); end
    txfifo_full = 1'b0;
    do_access(2'd1, 1'b1, 32'h10, 4'b0001, -1, -1, rdata, waits, rd_n, wr_n, txd);
    do_access(2'd1, 1'b0, 32'h0, 4'hF, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (rdata !== 32'h01) begin n_fail++; $display("FAIL drop_clear: got %h want 00000001", rdata); end
`endif
    txfifo_full = 1'b0;
  endtask

  task automatic test_sticky;
    @(negedge clk); rx_framing_error = 1'b1;
    @(negedge clk); rx_framing_error = 1'b0;
    do_access(2'd1, 1'b0, 32'h0, 4'hF, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (rdata !== 32'h09) begin n_fail++; $display("FAIL fe_set: got %h want 00000009", rdata); end
    // overflow pulse lands in the clearing ACCESS cycle: set wins
    do_access(2'd1, 1'b1, 32'h4, 4'b0001, 1, -1, rdata, waits, rd_n, wr_n, txd);
    do_access(2'd1, 1'b0, 32'h0, 4'hF, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (rdata !== 32'h0D) begin n_fail++; $display("FAIL ovf_setwins: got %h want 0000000d", rdata); end
    do_access(2'd1, 1'b1, 32'h4, 4'b0001, -1, -1, rdata, waits, rd_n, wr_n, txd);
    do_access(2'd1, 1'b0, 32'h0, 4'hF, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (rdata !== 32'h09) begin n_fail++; $display("FAIL ovf_clear: got %h want 00000009", rdata); end
    do_access(2'd1, 1'b1, 32'h8, 4'b0001, -1, -1, rdata, waits, rd_n, wr_n, txd);
    do_access(2'd1, 1'b0, 32'h0, 4'hF, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (rdata !== 32'h01) begin n_fail++; $display("FAIL fe_clear: got %h want 00000001", rdata); end
  endtask

  task automatic test_irq;
    do_access(2'd2, 1'b1, 32'h1, 4'b0001, -1, -1, rdata, waits, rd_n, wr_n, txd);
    @(negedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_rx_off: got %b want 0", irq); end
    rxfifo_empty = 1'b0; #1;
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rx_on: got %b want 1", irq); end
    rxfifo_empty = 1'b1;
    do_access(2'd2, 1'b1, 32'h2, 4'b0001, -1, -1, rdata, waits, rd_n, wr_n, txd);
    @(negedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_tx_on: got %b want 1", irq); end
    txfifo_full = 1'b1; #1;
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_tx_full: got %b want 0", irq); end
    do_access(2'd2, 1'b1, 32'h1, 4'b0000, -1, -1, rdata, waits, rd_n, wr_n, txd);
    do_access(2'd2, 1'b0, 32'h0, 4'hF, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (rdata !== 32'h2) begin n_fail++; $display("FAIL ctrl_rd: got %h want 00000002", rdata); end
    txfifo_full = 1'b0;
    do_access(2'd2, 1'b1, 32'h1, 4'b0001, -1, -1, rdata, waits, rd_n, wr_n, txd);
  endtask

  task automatic test_reset_mid_access;
    rxfifo_data = 9'h0AB; rxfifo_empty = 1'b0;
    @(negedge clk);
    bus_addr = 2'd0; bus_wren = 1'b0; bus_bytesel = 4'hF; bus_strobe = 1'b1;
    @(negedge clk);  // FSM now in ACCESS
    reset = 1'b1; #1;
    n_cmp++; if (rxfifo_rd !== 1'b0) begin n_fail++; $display("FAIL rstmid_pop: got %b want 0", rxfifo_rd); end
    @(negedge clk);
    reset = 1'b0; bus_strobe = 1'b0; #1;
    n_cmp++; if (bus_wait !== 1'b0) begin n_fail++; $display("FAIL rstmid_wait: got %b want 0", bus_wait); end
    n_cmp++; if (bus_rddata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rddata: got %h want 0", bus_rddata); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rstmid_irq: got %b want 0", irq); end
    rxfifo_empty = 1'b1;
    do_access(2'd2, 1'b0, 32'h0, 4'hF, -1, -1, rdata, waits, rd_n, wr_n, txd);
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_ctrl: got %h want 0", rdata); end
  endtask

  initial begin
    reset = 1'b1; bus_addr = '0; bus_wrdata = '0; bus_bytesel = '0;
    bus_wren = 1'b0; bus_strobe = 1'b0; txfifo_full = 1'b0;
    rxfifo_data = '0; rxfifo_empty = 1'b1; rxfifo_overflow = 1'b0;
    rx_framing_error = 1'b0;
    test_reset;
    test_status;
    test_data_read;
    test_data_write;
    test_tx_full;
    test_sticky;
    test_irq;
    test_reset_mid_access;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
